// File: rtl/ts_stream_checker.sv
// ts_stream_checker: sink-side monitor for a 188-byte TS byte stream.
// Acquires packet sync (SEARCH -> VERIFY -> LOCKED with a flywheel), decodes
// the 13-bit PID and checks the 4-bit continuity counter of one selected PID.
//
// Ports:
//   CLK_IN        clock, rising edge
//   RST           asynchronous active-low reset
//   DATA/DVALID   stream byte and qualifier (DVALID=0 bytes are ignored)
//   PSYNC         packet-start flag from the producer
//   PID_SEL       PID subject to the continuity check
//   CLR_CNT       synchronous clear of all counters (wins over increments)
//   LOCKED        high while locked
//   PKT_START     pulse per accepted sync byte while locked
//   PID_OUT       PID of the current packet, PID_MATCH = PID_OUT == PID_SEL
//   SYNC_ERR      pulse per missed sync while locked
//   CC_ERR        pulse per continuity error
//   SYNC_ERR_CNT  saturating SYNC_ERR count
//   CC_ERR_CNT    saturating CC_ERR count
//   PKT_CNT       wrapping PKT_START count
// All outputs are registered: they reflect the byte sampled on the previous edge.
module ts_stream_checker #(
    parameter int unsigned PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter bit          USE_PSYNC  = 1'b1
) (
    input  logic        CLK_IN,
    input  logic        RST,
    input  logic [7:0]  DATA,
    input  logic        DVALID,
    input  logic        PSYNC,
    input  logic [12:0] PID_SEL,
    input  logic        CLR_CNT,
    output logic        LOCKED,
    output logic        PKT_START,
    output logic [12:0] PID_OUT,
    output logic        PID_MATCH,
    output logic        SYNC_ERR,
    output logic        CC_ERR,
    output logic [15:0] SYNC_ERR_CNT,
    output logic [15:0] CC_ERR_CNT,
    output logic [31:0] PKT_CNT
);

    localparam int unsigned     IdxW       = $clog2(PKT_LEN);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(PKT_LEN - 1);
    localparam logic [IdxW-1:0] IdxOne     = IdxW'(1);
    localparam logic [7:0]      LockCntV   = 8'(LOCK_CNT);
    localparam logic [7:0]      UnlockCntV = 8'(UNLOCK_CNT);

    localparam logic [1:0] StSearch = 2'd0;
    localparam logic [1:0] StVerify = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      good_q, good_d;
    logic [7:0]      miss_q, miss_d;
    logic [4:0]      pid_hi_q, pid_hi_d;
    logic [12:0]     pid_out_q, pid_out_d;
    logic            pid_match_q, pid_match_d;
    logic [12:0]     pid_sel_q;
    logic [3:0]      cc_prev_q, cc_prev_d;
    logic            cc_valid_q, cc_valid_d;
    logic            pkt_start_q, pkt_start_d;
    logic            sync_err_q, sync_err_d;
    logic            cc_err_q, cc_err_d;
    logic [15:0]     sync_err_cnt_q, sync_err_cnt_d;
    logic [15:0]     cc_err_cnt_q, cc_err_cnt_d;
    logic [31:0]     pkt_cnt_q, pkt_cnt_d;

    logic            sync_mark;
    logic [IdxW-1:0] idx_inc;

    assign sync_mark = DVALID && (DATA == SYNC_BYTE) && (PSYNC || !USE_PSYNC);
    assign idx_inc   = (idx_q == IdxLast) ? '0 : idx_q + IdxOne;

    // Sync tracking and header decode
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        good_d      = good_q;
        miss_d      = miss_q;
        pid_hi_d    = pid_hi_q;
        pid_out_d   = pid_out_q;
        pid_match_d = pid_match_q;
        cc_prev_d   = cc_prev_q;
        cc_valid_d  = cc_valid_q;
        pkt_start_d = 1'b0;
        sync_err_d  = 1'b0;
        cc_err_d    = 1'b0;

        if (DVALID) begin
            case (state_q)
                StSearch: begin
                    if (sync_mark) begin
                        idx_d   = IdxOne;
                        good_d  = 8'd1;
                        state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (idx_q == '0) begin
                        if (sync_mark) begin
                            idx_d  = IdxOne;
                            good_d = good_q + 8'd1;
                            if (good_q + 8'd1 == LockCntV) begin
                                state_d     = StLocked;
                                pkt_start_d = 1'b1;
                                miss_d      = 8'd0;
                            end
                        end else begin
                            // The failing byte is dropped, not retried as a candidate.
                            state_d = StSearch;
                            idx_d   = '0;
                            good_d  = 8'd0;
                        end
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                StLocked: begin
                    if (idx_q == '0) begin
                        // Flywheel: index advances whether or not the sync was seen.
                        idx_d = IdxOne;
                        if (sync_mark) begin
                            pkt_start_d = 1'b1;
                            miss_d      = 8'd0;
                        end else begin
                            sync_err_d = 1'b1;
                            miss_d     = miss_q + 8'd1;
                            if (miss_q + 8'd1 == UnlockCntV) begin
                                state_d    = StSearch;
                                cc_valid_d = 1'b0;
                                idx_d      = '0;
                                good_d     = 8'd0;
                            end
                        end
                    end else begin
                        idx_d = idx_inc;
                        if (idx_q == IdxW'(1)) begin
                            pid_hi_d = DATA[4:0];
                        end else if (idx_q == IdxW'(2)) begin
                            pid_out_d   = {pid_hi_q, DATA};
                            pid_match_d = ({pid_hi_q, DATA} == PID_SEL);
                        end else if (idx_q == IdxW'(3)) begin
                            if (pid_match_q) begin
                                if (cc_valid_q && (DATA[3:0] != cc_prev_q + 4'd1)) begin
                                    cc_err_d = 1'b1;
                                end
                                cc_prev_d  = DATA[3:0];
                                cc_valid_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                    idx_d   = '0;
                end
            endcase
        end

        // A new selection starts a fresh CC history.
        if (PID_SEL != pid_sel_q) begin
            cc_valid_d = 1'b0;
        end
    end

    // Event counters; CLR_CNT beats a same-cycle increment.
    always_comb begin
        sync_err_cnt_d = sync_err_cnt_q;
        cc_err_cnt_d   = cc_err_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        if (CLR_CNT) begin
            sync_err_cnt_d = 16'd0;
            cc_err_cnt_d   = 16'd0;
            pkt_cnt_d      = 32'd0;
        end else begin
            if (sync_err_d && (sync_err_cnt_q != 16'hFFFF)) begin
                sync_err_cnt_d = sync_err_cnt_q + 16'd1;
            end
            if (cc_err_d && (cc_err_cnt_q != 16'hFFFF)) begin
                cc_err_cnt_d = cc_err_cnt_q + 16'd1;
            end
            if (pkt_start_d) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_q        <= StSearch;
            idx_q          <= '0;
            good_q         <= 8'd0;
            miss_q         <= 8'd0;
            pid_hi_q       <= 5'd0;
            pid_out_q      <= 13'd0;
            pid_match_q    <= 1'b0;
            pid_sel_q      <= 13'd0;
            cc_prev_q      <= 4'd0;
            cc_valid_q     <= 1'b0;
            pkt_start_q    <= 1'b0;
            sync_err_q     <= 1'b0;
            cc_err_q       <= 1'b0;
            sync_err_cnt_q <= 16'd0;
            cc_err_cnt_q   <= 16'd0;
            pkt_cnt_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            good_q         <= good_d;
            miss_q         <= miss_d;
            pid_hi_q       <= pid_hi_d;
            pid_out_q      <= pid_out_d;
            pid_match_q    <= pid_match_d;
            pid_sel_q      <= PID_SEL;
            cc_prev_q      <= cc_prev_d;
            cc_valid_q     <= cc_valid_d;
            pkt_start_q    <= pkt_start_d;
            sync_err_q     <= sync_err_d;
            cc_err_q       <= cc_err_d;
            sync_err_cnt_q <= sync_err_cnt_d;
            cc_err_cnt_q   <= cc_err_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
        end
    end

    assign LOCKED       = (state_q == StLocked);
    assign PKT_START    = pkt_start_q;
    assign PID_OUT      = pid_out_q;
    assign PID_MATCH    = pid_match_q;
    assign SYNC_ERR     = sync_err_q;
    assign CC_ERR       = cc_err_q;
    assign SYNC_ERR_CNT = sync_err_cnt_q;
    assign CC_ERR_CNT   = cc_err_cnt_q;
    assign PKT_CNT      = pkt_cnt_q;

endmodule
